// File: rtl/arb_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
//   arb_state_t : two-state arbitration FSM encoding (idle / grant held).
//   ARB_N_REQ   : number of requesters.
//   ARB_IDX_W   : width of a requester index.
package arb_pkg;

  localparam int ARB_N_REQ = 8;
  localparam int ARB_IDX_W = 3;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/arb_onehot_enc.sv
// One-hot to binary encoder used to derive the grant index from the next
// grant vector, so the index and the grant are registered in the same edge.
//   onehot : 8-bit grant vector (expected one-hot or zero).
//   idx    : binary index of the set bit; 3'd0 for zero or non-one-hot input.
module arb_onehot_enc
  import arb_pkg::*;
(
  input  logic [ARB_N_REQ-1:0] onehot,
  output logic [ARB_IDX_W-1:0] idx
);

  // Exact-match table: anything that is not a single set bit maps to 0.
  always_comb begin
    idx = 3'd0;
    case (onehot)
      8'h01:   idx = 3'd0;
      8'h02:   idx = 3'd1;
      8'h04:   idx = 3'd2;
      8'h08:   idx = 3'd3;
      8'h10:   idx = 3'd4;
      8'h20:   idx = 3'd5;
      8'h40:   idx = 3'd6;
      8'h80:   idx = 3'd7;
      default: idx = 3'd0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter sharing one resource between 8 requesters.
// A winner keeps its grant until it drops its request; every tenure is
// followed by one idle cycle before the next arbitration.
//   clk       : rising-edge clock.
//   rst_n     : asynchronous active-low reset.
//   req       : level request per requester, held for the whole tenure.
//   gnt       : registered one-hot grant, zero when idle.
//   gnt_idx   : binary index of the granted requester, 0 when idle.
//   gnt_valid : high whenever gnt is non-zero.
//   timeout   : one-cycle pulse when a grant is forcibly revoked.
// Optional feature: define ARB_TIMEOUT_EN to bound every tenure to MAX_HOLD
// grant cycles. Without it, timeout is tied low and tenure is unbounded.
module rr_arbiter_8
  import arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ARB_N_REQ-1:0] req,
  output logic [ARB_N_REQ-1:0] gnt,
  output logic [ARB_IDX_W-1:0] gnt_idx,
  output logic                 gnt_valid,
  output logic                 timeout
);

  arb_state_t           state_q, state_d;
  logic [ARB_N_REQ-1:0] gnt_q, gnt_d;
  logic [ARB_IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic                 gnt_valid_q, gnt_valid_d;
  logic [ARB_IDX_W-1:0] last_idx_q, last_idx_d;

  logic [ARB_IDX_W-1:0] pick_idx_s;
  logic [ARB_IDX_W-1:0] cand_idx_s;
  logic                 pick_found_s;

`ifdef ARB_TIMEOUT_EN
  localparam int MAX_HOLD = 16;
  localparam int HOLD_W   = $clog2(MAX_HOLD);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              timeout_q, timeout_d;
`endif

  // Rotating-priority pick: scan from farthest to nearest after last_idx so
  // the nearest requesting slot is the one left standing.
  always_comb begin
    pick_found_s = |req;
    pick_idx_s   = 3'd0;
    cand_idx_s   = 3'd0;
    for (int k = ARB_N_REQ; k >= 1; k--) begin
      cand_idx_s = last_idx_q + ARB_IDX_W'(k);
      if (req[cand_idx_s]) begin
        pick_idx_s = cand_idx_s;
      end else begin
        pick_idx_s = pick_idx_s;
      end
    end
  end

  // Next-state and next-grant logic for the idle/grant FSM.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_idx_d = last_idx_q;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_found_s) begin
          state_d    = ARB_GRANT;
          gnt_d      = 8'h01 << pick_idx_s;
          last_idx_d = pick_idx_s;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end else begin
          gnt_d = 8'h00;
        end
      end
      ARB_GRANT: begin
        if (!req[gnt_idx_q]) begin
          state_d = ARB_IDLE;
          gnt_d   = 8'h00;
        end
`ifdef ARB_TIMEOUT_EN
        // Counter value MAX_HOLD-1 marks the last allowed grant cycle.
        // last_idx is left on the revoked owner so the others go first.
        else if (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) begin
          state_d   = ARB_IDLE;
          gnt_d     = 8'h00;
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
`else
        else begin
          gnt_d = gnt_q;
        end
`endif
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = 8'h00;
      end
    endcase
    gnt_valid_d = |gnt_d;
  end

  arb_onehot_enc u_enc (
    .onehot (gnt_d),
    .idx    (gnt_idx_d)
  );

  // FSM state, grant outputs and rotation pointer; pointer resets to the
  // top index so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= 8'h00;
      gnt_idx_q   <= 3'd0;
      gnt_valid_q <= 1'b0;
      last_idx_q  <= 3'd7;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      last_idx_q  <= last_idx_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Tenure counter and registered revocation pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;

endmodule
